// File: rtl/cpuDefine.sv
// Shared types for the CPU memory-side blocks: arbiter FSM states, bus owner
// and the held bus request payload.
package cpuDefine;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_REQ  = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } arb_owner_e;

   typedef struct packed {
      logic        wr;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_payload_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto a single-outstanding memory bus.
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
//
// Handshake: a request is taken when req=1 and addr_ok=1 in the same cycle;
// a response is delivered in the single cycle data_ok=1; the bus side holds
// bus_req and its payload stable until bus_addr_ok, then waits for bus_data_ok.
module mem_bus_arbiter
   import cpuDefine::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic        aclk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   input  logic        inst_cancel,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] rsp_rdata,
   output logic        bus_req,
   output logic        bus_wr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_addr_ok,
   input  logic        bus_data_ok,
   input  logic [31:0] bus_rdata,
   output logic [1:0]  dbg_state
);

   arb_state_e   state_q, state_d;
   arb_owner_e   owner_q, owner_d;
   logic         drop_q, drop_d;
   bus_payload_t pay_q, pay_d;
   logic         force_inst;
   logic         inst_win;
   logic         data_win;

   assign inst_win = inst_req && (!data_req || force_inst);
   assign data_win = data_req && !inst_win;

`ifdef ARB_STARVE_GUARD_EN
   localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   logic [CW-1:0] starve_q, starve_d;

   assign force_inst = (starve_q == CW'(STARVE_MAX));

   always_comb begin
      starve_d = starve_q;
      if (state_q == ARB_IDLE && !reset) begin
         if (inst_win)
            starve_d = '0;
         else if (data_win)
            starve_d = !inst_req ? '0 : (force_inst ? starve_q : starve_q + CW'(1));
      end
   end

   always_ff @(posedge aclk) begin
      if (reset) starve_q <= '0;
      else       starve_q <= starve_d;
   end
`else
   // Data always wins contention; this term is a constant 0.
   assign force_inst = (STARVE_MAX < 0);
`endif

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      drop_d       = drop_q;
      pay_d        = pay_q;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      data_data_ok = 1'b0;
      bus_req      = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            drop_d = 1'b0;
            if (inst_win) begin
               inst_addr_ok = 1'b1;
               owner_d      = OWN_INST;
               pay_d        = '{wr: 1'b0, wstrb: 4'h0, addr: inst_addr, wdata: 32'h0};
               state_d      = ARB_REQ;
            end else if (data_win) begin
               data_addr_ok = 1'b1;
               owner_d      = OWN_DATA;
               pay_d        = '{wr: data_wr, wstrb: data_wstrb, addr: data_addr, wdata: data_wdata};
               state_d      = ARB_REQ;
            end
         end
         ARB_REQ: begin
            bus_req = 1'b1;
            if (owner_q == OWN_INST && inst_cancel) drop_d = 1'b1;
            if (bus_addr_ok) state_d = ARB_RESP;
         end
         ARB_RESP: begin
            if (owner_q == OWN_INST && inst_cancel) drop_d = 1'b1;
            if (bus_data_ok) begin
               // A cancel arriving with the response itself still drops it.
               if (owner_q == OWN_DATA) data_data_ok = 1'b1;
               else                     inst_data_ok = !drop_q && !inst_cancel;
               drop_d  = 1'b0;
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
      if (reset) begin
         inst_addr_ok = 1'b0;
         data_addr_ok = 1'b0;
         inst_data_ok = 1'b0;
         data_data_ok = 1'b0;
         bus_req      = 1'b0;
      end
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         owner_q <= OWN_INST;
         drop_q  <= 1'b0;
         pay_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         drop_q  <= drop_d;
         pay_q   <= pay_d;
      end
   end

   assign rsp_rdata = bus_rdata;
   assign bus_wr    = bus_req & pay_q.wr;
   assign bus_wstrb = {4{bus_req}} & pay_q.wstrb;
   assign bus_addr  = {32{bus_req}} & pay_q.addr;
   assign bus_wdata = {32{bus_req}} & pay_q.wdata;
   assign dbg_state = reset ? ARB_IDLE : state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: drivers push expected responses into a
// queue, a negedge monitor pops and compares on every data_ok.
module tb_mem_bus_arbiter;

   logic        aclk = 1'b0;
   logic        reset;
   logic        inst_req, inst_cancel;
   logic [31:0] inst_addr;
   logic        inst_addr_ok, inst_data_ok;
   logic        data_req, data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] rsp_rdata;
   logic        bus_req, bus_wr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_addr, bus_wdata;
   logic        bus_addr_ok, bus_data_ok;
   logic [31:0] bus_rdata;
   logic [1:0]  dbg_state;

   int n_vec = 0;
   int n_err = 0;

   // {is_data, rdata}
   logic [32:0] exp_q[$];

   always #5 aclk = ~aclk;

   mem_bus_arbiter #(.STARVE_MAX(4)) dut (
      .aclk(aclk), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .inst_cancel(inst_cancel),
      .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .rsp_rdata(rsp_rdata),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
      .bus_rdata(bus_rdata),
      .dbg_state(dbg_state)
   );

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every response must match the oldest expected entry.
   always @(negedge aclk) begin
      logic [32:0] exp_r;
      if (inst_data_ok || data_data_ok) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL spurious_data_ok: inst=%0b data=%0b rdata=%h, none expected",
                     inst_data_ok, data_data_ok, rsp_rdata);
         end else begin
            exp_r = exp_q.pop_front();
            if ({data_data_ok, rsp_rdata} !== exp_r || (inst_data_ok && data_data_ok)) begin
               n_err++;
               $display("FAIL response: got inst=%0b data=%0b rdata=%h expected data=%0b rdata=%h",
                        inst_data_ok, data_data_ok, rsp_rdata, exp_r[32], exp_r[31:0]);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic exp_inst;
      reset = 1'b1; inst_req = 1'b1; inst_cancel = 1'b0; inst_addr = 32'h1c00_0000;
      data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF; data_addr = 32'h8000_0000;
      data_wdata = 32'h1; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h55AA_1234;

      // Reset: requests and stale handshakes must be ignored.
      repeat (3) tick();
      @(negedge aclk);
      chk("rst_inst_addr_ok", inst_addr_ok, 0);
      chk("rst_data_addr_ok", data_addr_ok, 0);
      chk("rst_bus_req", bus_req, 0);
      chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
      chk("rst_bus_addr", bus_addr, 0);
      chk("rst_state", dbg_state, 0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h55AA_1234);
      tick();
      reset = 1'b0; inst_req = 1'b0; data_req = 1'b0; bus_data_ok = 1'b0;

      // Inst-only fetch at minimum latency.
      tick();
      inst_req = 1'b1; inst_addr = 32'h1c00_0000;
      @(negedge aclk);
      chk("t1_inst_addr_ok", inst_addr_ok, 1);
      chk("t1_data_addr_ok", data_addr_ok, 0);
      chk("t1_c0_bus_req", bus_req, 0);
      tick();
      inst_req = 1'b0; bus_addr_ok = 1'b1;
      @(negedge aclk);
      chk("t1_c1_bus_req", bus_req, 1);
      chk("t1_bus_addr", bus_addr, 32'h1c00_0000);
      chk("t1_bus_wr", bus_wr, 0);
      chk("t1_bus_wstrb", bus_wstrb, 0);
      tick();
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0280_0000;
      exp_q.push_back({1'b0, 32'h0280_0000});
      @(negedge aclk);
      chk("t1_rsp_rdata", rsp_rdata, 32'h0280_0000);
      chk("t1_c2_bus_req", bus_req, 0);
      tick();
      @(negedge aclk);
      chk("t1_idle_bus_req", bus_req, 0);
      tick();
      bus_data_ok = 1'b0;

      // Contention: store wins, held payload, inst waits for IDLE.
      inst_req = 1'b1; inst_addr = 32'h1c00_0040;
      data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF;
      data_addr = 32'h8000_1000; data_wdata = 32'hDEAD_BEEF;
      @(negedge aclk);
      chk("t2_data_addr_ok", data_addr_ok, 1);
      chk("t2_inst_addr_ok", inst_addr_ok, 0);
      tick();
      data_req = 1'b0; data_wdata = 32'h0; data_addr = 32'h0;
      @(negedge aclk);
      chk("t2_bus_req", bus_req, 1);
      chk("t2_bus_wr", bus_wr, 1);
      chk("t2_bus_wstrb", bus_wstrb, 4'hF);
      chk("t2_bus_addr", bus_addr, 32'h8000_1000);
      chk("t2_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
      chk("t2_req_inst_addr_ok", inst_addr_ok, 0);
      tick();
      bus_addr_ok = 1'b1;
      @(negedge aclk);
      chk("t2_hold_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
      chk("t2_hold_bus_req", bus_req, 1);
      tick();
      bus_addr_ok = 1'b0;
      @(negedge aclk);
      chk("t2_resp_bus_req", bus_req, 0);
      chk("t2_resp_inst_addr_ok", inst_addr_ok, 0);
      tick();
      bus_data_ok = 1'b1; bus_rdata = 32'h0;
      exp_q.push_back({1'b1, 32'h0});
      @(negedge aclk);
      chk("t2_done_inst_addr_ok", inst_addr_ok, 0);
      tick();
      bus_data_ok = 1'b0;
      @(negedge aclk);
      chk("t2_idle_inst_addr_ok", inst_addr_ok, 1);
      tick();
      inst_req = 1'b0; bus_addr_ok = 1'b1;
      @(negedge aclk);
      chk("t2_inst_bus_addr", bus_addr, 32'h1c00_0040);
      chk("t2_inst_bus_wr", bus_wr, 0);
      tick();
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1111_2222;
      exp_q.push_back({1'b0, 32'h1111_2222});
      tick();
      bus_data_ok = 1'b0;

      // Cancel in RESP, response three cycles later is dropped.
      inst_req = 1'b1; inst_addr = 32'h1c00_0080;
      @(negedge aclk);
      chk("t3_inst_addr_ok", inst_addr_ok, 1);
      tick();
      inst_req = 1'b0; bus_addr_ok = 1'b1;
      tick();
      bus_addr_ok = 1'b0; inst_cancel = 1'b1;
      tick();
      inst_cancel = 1'b0;
      tick();
      tick();
      bus_data_ok = 1'b1; bus_rdata = 32'hBAD0_BAD0;
      @(negedge aclk);
      chk("t3_dropped_inst_data_ok", inst_data_ok, 0);
      tick();
      bus_data_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'h1c00_0084;
      @(negedge aclk);
      chk("t3_next_inst_addr_ok", inst_addr_ok, 1);
      tick();
      inst_req = 1'b0; bus_addr_ok = 1'b1;
      @(negedge aclk);
      chk("t3_next_bus_addr", bus_addr, 32'h1c00_0084);
      tick();
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0000_0084;
      exp_q.push_back({1'b0, 32'h0000_0084});
      tick();
      bus_data_ok = 1'b0;

      // Cancel while still in REQ also drops the response.
      inst_req = 1'b1; inst_addr = 32'h1c00_00c0;
      tick();
      inst_req = 1'b0; inst_cancel = 1'b1;
      tick();
      inst_cancel = 1'b0; bus_addr_ok = 1'b1;
      tick();
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hBAD1_BAD1;
      @(negedge aclk);
      chk("t4_dropped_inst_data_ok", inst_data_ok, 0);
      tick();
      bus_data_ok = 1'b0;

      // Cancel in the same cycle as the response.
      inst_req = 1'b1; inst_addr = 32'h1c00_0100;
      tick();
      inst_req = 1'b0; bus_addr_ok = 1'b1;
      tick();
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; inst_cancel = 1'b1; bus_rdata = 32'hBAD2_BAD2;
      @(negedge aclk);
      chk("t5_samecycle_inst_data_ok", inst_data_ok, 0);
      tick();
      bus_data_ok = 1'b0;

      // Cancel (still asserted) during a data load has no effect.
      data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'h0; data_addr = 32'h8000_2000;
      @(negedge aclk);
      chk("t6_data_addr_ok", data_addr_ok, 1);
      tick();
      data_req = 1'b0; bus_addr_ok = 1'b1;
      @(negedge aclk);
      chk("t6_bus_wr", bus_wr, 0);
      chk("t6_bus_addr", bus_addr, 32'h8000_2000);
      tick();
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D;
      exp_q.push_back({1'b1, 32'hCAFE_F00D});
      tick();
      bus_data_ok = 1'b0; inst_cancel = 1'b0;

      // Reset in REQ abandons the transaction; stale bus_data_ok is ignored.
      inst_req = 1'b1; inst_addr = 32'h1c00_0140;
      tick();
      inst_req = 1'b0; reset = 1'b1;
      @(negedge aclk);
      chk("t7_rst_bus_req", bus_req, 0);
      tick();
      reset = 1'b0;
      @(negedge aclk);
      chk("t7_after_bus_req", bus_req, 0);
      chk("t7_after_state", dbg_state, 0);
      tick();
      bus_data_ok = 1'b1; bus_rdata = 32'hBAD3_BAD3;
      @(negedge aclk);
      chk("t7_stale_inst_data_ok", inst_data_ok, 0);
      tick();
      bus_data_ok = 1'b0;

      // Sustained contention: grant pattern over ten transactions.
      inst_req = 1'b1; inst_addr = 32'h1c00_0180;
      data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'h0; data_addr = 32'h9000_0000;
      for (int g = 0; g < 10; g++) begin
`ifdef ARB_STARVE_GUARD_EN
         exp_inst = ((g % 5) == 4);
`else
         exp_inst = 1'b0;
`endif
         @(negedge aclk);
         chk($sformatf("t8_g%0d_inst_addr_ok", g), inst_addr_ok, exp_inst);
         chk($sformatf("t8_g%0d_data_addr_ok", g), data_addr_ok, !exp_inst);
         tick();
         bus_addr_ok = 1'b1;
         @(negedge aclk);
         chk($sformatf("t8_g%0d_bus_addr", g), bus_addr,
             exp_inst ? 32'h1c00_0180 : 32'h9000_0000);
         tick();
         bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'(g);
         exp_q.push_back({!exp_inst, 32'(g)});
         tick();
         bus_data_ok = 1'b0;
      end
      inst_req = 1'b0; data_req = 1'b0;
      repeat (3) tick();

      chk("exp_q_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive contended data grants allowed before inst is forced to win.
REQ-002 aclk  in  1  sole clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 inst_req  in  1  IF fetch request, read only.
REQ-005 inst_addr  in  32  fetch address.
REQ-006 inst_addr_ok  out  1  fetch request accepted this cycle.
REQ-007 inst_data_ok  out  1  fetch response valid on rsp_rdata.
REQ-008 inst_cancel  in  1  pipeline flush: discard any pending fetch response.
REQ-009 data_req  in  1  MEM-stage load/store request.
REQ-010 data_wr  in  1  1 = store, 0 = load.
REQ-011 data_wstrb  in  4  store byte enables.
REQ-012 data_addr  in  32  load/store address.
REQ-013 data_wdata  in  32  store data.
REQ-014 data_addr_ok  out  1  data request accepted this cycle.
REQ-015 data_data_ok  out  1  load data valid, or store completed.
REQ-016 rsp_rdata  out  32  response data shared by both requesters, equal to bus_rdata.
REQ-017 bus_req, bus_wr, bus_wstrb[4], bus_addr[32], bus_wdata[32]  out  request to the shared memory bus.
REQ-018 bus_addr_ok, bus_data_ok  in  1 each; bus_rdata  in  32  bus handshake and read data.

Function
REQ-019 The FSM SHALL have three states: IDLE, REQ and RESP, with one bus transaction outstanding at most.
REQ-020 In IDLE with any request pending, the winner's addr_ok SHALL be 1 in the same cycle; the owner and payload (inst reads force wr=0, wstrb=0) SHALL be captured; the next state SHALL be REQ.
REQ-021 If both requests are pending in IDLE, data SHALL win and inst_addr_ok SHALL be 0, except as set by REQ-030.
REQ-022 In REQ, bus_req SHALL be 1 and carry the held payload unchanged until bus_addr_ok; on bus_addr_ok the next state SHALL be RESP.
REQ-023 In RESP, on bus_data_ok the owner's data_ok SHALL be 1 in the same cycle and the next state SHALL be IDLE.
REQ-024 Minimum latency: accept in cycle 0, bus_req in cycle 1, owner data_ok in cycle 2.
REQ-025 bus_req SHALL be 0 in IDLE and RESP; bus_data_ok in IDLE or REQ SHALL be ignored.
REQ-026 inst_cancel while an inst transaction is in REQ or RESP SHALL set a drop flag. The transaction SHALL still complete on the bus, inst_data_ok SHALL be suppressed, and the flag SHALL clear on return to IDLE.
REQ-027 inst_cancel in the same cycle as the inst bus_data_ok SHALL suppress inst_data_ok. inst_cancel in IDLE or during a data transaction SHALL have no effect.
REQ-028 addr_ok for either requester SHALL be 0 outside IDLE.

Reset
REQ-029 When reset is 1: state=IDLE, drop flag=0, starvation counter=0, held payload=0; all outputs 0 except rsp_rdata, which follows bus_rdata. Reset mid-transaction abandons the transaction and issues no data_ok.

Configuration
REQ-030 With ARB_STARVE_GUARD_EN defined: a saturating counter SHALL increment on each data grant made while inst_req=1, and clear on an inst grant or on a data grant with inst_req=0. When the counter equals STARVE_MAX, contention SHALL go to inst. Without the macro, data SHALL always win and no counter SHALL exist.

Structure
REQ-031 The state enum (ARB_IDLE/ARB_REQ/ARB_RESP) and the owner enum (OWN_INST/OWN_DATA) SHALL live in cpuDefine.
REQ-032 The block SHALL be a single module with no sub-modules.

Verification
REQ-033 Inst-only fetch: inst_addr=0x1c000000, bus_addr_ok in cycle 1, bus_data_ok with bus_rdata=0x02800000 in cycle 2 -> inst_addr_ok in cycle 0, inst_data_ok and rsp_rdata=0x02800000 in cycle 2.
REQ-034 inst_req and data_req (store, wstrb=0xF, wdata=0xDEADBEEF) in the same cycle -> data_addr_ok=1, inst_addr_ok=0; bus_wr=1 with that payload; inst is accepted in the first IDLE after data_data_ok.
REQ-035 inst in RESP, inst_cancel pulsed, bus_data_ok 3 cycles later -> inst_data_ok never 1; the next inst request is accepted normally.
REQ-036 With ARB_STARVE_GUARD_EN and STARVE_MAX=4, inst_req and data_req held at 1 -> grants data, data, data, data, inst, repeating.
REQ-037 Reset asserted in REQ -> bus_req=0 and no data_ok on the next cycle; a stale bus_data_ok afterwards produces no data_ok.
